// File: rtl/note_sequencer.sv
// note_sequencer: records keypad note events (value, tone, hold time) into a
// DEPTH-entry buffer and replays them to the tone generator with the original
// timing, once or looped.
module note_sequencer #(
    parameter int VAL_W    = 3,
    parameter int TONE_W   = 2,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic              loop,
    input  logic [VAL_W-1:0]  value_in,
    input  logic [TONE_W-1:0] tone_in,
    output logic [VAL_W-1:0]  value_out,
    output logic [TONE_W-1:0] tone_out,
    output logic              playing,
    output logic              recording,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = VAL_W + TONE_W + DUR_W;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

    // synchroniser chains; *_p_q holds the previous synced value for edges
    logic              rec_m_q, rec_s_q, rec_p_q;
    logic              play_m_q, play_s_q, play_p_q;
    logic [VAL_W-1:0]  val_m_q, val_s_q;
    logic [TONE_W-1:0] tone_s_q;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0]    dcnt_q, dcnt_d;
    logic [DUR_W-1:0]    cur_dur_q, cur_dur_d;
    logic                open_q, open_d;
    logic [VAL_W-1:0]    open_val_q, open_val_d;
    logic [TONE_W-1:0]   open_tone_q, open_tone_d;
    logic [VAL_W-1:0]    vout_q, vout_d;
    logic [TONE_W-1:0]   tout_q, tout_d;

    logic [ENT_W-1:0]    mem [DEPTH];
    logic [ENT_W-1:0]    rd_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [ENT_W-1:0]    wdata;

    logic                play_rise, rec_rise, tick, dur_inc, last_idx;
    logic                entry_done, val_changed;
    logic [DUR_W-1:0]    dcnt_next, close_dur;
    logic [ADDR_W-1:0]   nxt_idx;
    logic [VAL_W-1:0]    rd_val;
    logic [TONE_W-1:0]   rd_tone;
    logic [DUR_W-1:0]    rd_dur;

    // Bring the asynchronous switches and live note into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_m_q  <= 1'b0;
            rec_s_q  <= 1'b0;
            rec_p_q  <= 1'b0;
            play_m_q <= 1'b0;
            play_s_q <= 1'b0;
            play_p_q <= 1'b0;
            val_m_q  <= '0;
            val_s_q  <= '0;
            tone_s_q <= '0;
        end else begin
            rec_m_q  <= rec_en;
            rec_s_q  <= rec_m_q;
            rec_p_q  <= rec_s_q;
            play_m_q <= play_en;
            play_s_q <= play_m_q;
            play_p_q <= play_s_q;
            val_m_q  <= value_in;
            val_s_q  <= val_m_q;
            tone_s_q <= tone_in;
        end
    end

    assign play_rise   = play_s_q & ~play_p_q;
    assign rec_rise    = rec_s_q & ~rec_p_q;
    assign tick        = (presc_q == PRE_LAST);
    // duration so far, counting a tick that lands in the closing cycle
    assign dur_inc     = tick && (dcnt_q != DUR_MAX);
    assign dcnt_next   = dur_inc ? dcnt_q + 1'b1 : dcnt_q;
    assign close_dur   = (dcnt_next == '0) ? DUR_W'(1) : dcnt_next;
    assign last_idx    = ({1'b0, idx_q} == (count_q - 1'b1));
    assign nxt_idx     = last_idx ? '0 : idx_q + 1'b1;
    // a stored dur of 0 can only come from an unwritten slot; treat it as 1
    assign entry_done  = tick && (({1'b0, dcnt_q} + 1'b1) >= {1'b0, cur_dur_q});
    assign val_changed = open_q ? (val_s_q != open_val_q) : (val_s_q != '0);
    assign rd_val      = rd_q[ENT_W-1 -: VAL_W];
    assign rd_tone     = rd_q[DUR_W +: TONE_W];
    assign rd_dur      = rd_q[DUR_W-1:0];
    // prefetch the entry that follows the current one so advances have no bubble
    assign rd_addr     = (state_q == S_PLAY) ? nxt_idx : '0;

    // Entry buffer: synchronous write port, registered read port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[rd_addr];
    end

    // Next-state, buffer write and playback output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        full_d      = full_q;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        dcnt_d      = dcnt_next;
        cur_dur_d   = cur_dur_q;
        open_d      = open_q;
        open_val_d  = open_val_q;
        open_tone_d = open_tone_q;
        vout_d      = '0;
        tout_d      = '0;
        we          = 1'b0;
        waddr       = count_q[ADDR_W-1:0];
        wdata       = {open_val_q, open_tone_q, close_dur};

        case (state_q)
            S_IDLE: begin
                open_d = 1'b0;
                if (rec_s_q) begin
                    state_d = S_REC;
                    count_d = '0;
                    full_d  = 1'b0;
                end else if (play_rise && (count_q != '0)) begin
                    state_d   = S_PLAY;
                    idx_d     = '0;
                    presc_d   = '0;
                    dcnt_d    = '0;
                    cur_dur_d = rd_dur;
                    vout_d    = rd_val;
                    tout_d    = rd_tone;
                end
            end
            S_REC: begin
                if (!rec_s_q) begin
                    // only a sounding note is kept; a trailing rest is dropped
                    state_d = S_IDLE;
                    open_d  = 1'b0;
                    if (open_q && (open_val_q != '0) && !full_q) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                        full_d  = ((count_q + 1'b1) == CNT_FULL);
                    end
                end else if (val_changed) begin
                    if (open_q && !full_q) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                        full_d  = ((count_q + 1'b1) == CNT_FULL);
                    end
                    open_d      = 1'b1;
                    open_val_d  = val_s_q;
                    open_tone_d = tone_s_q;
                    presc_d     = '0;
                    dcnt_d      = '0;
                end
            end
            S_PLAY: begin
                vout_d = vout_q;
                tout_d = tout_q;
                if (!play_s_q || rec_rise) begin
                    state_d = S_IDLE;
                    vout_d  = '0;
                    tout_d  = '0;
                end else if (entry_done) begin
                    if (last_idx && !loop) begin
                        state_d = S_IDLE;
                        vout_d  = '0;
                        tout_d  = '0;
                    end else begin
                        idx_d     = nxt_idx;
                        presc_d   = '0;
                        dcnt_d    = '0;
                        cur_dur_d = rd_dur;
                        vout_d    = rd_val;
                        tout_d    = rd_tone;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            presc_q     <= '0;
            dcnt_q      <= '0;
            cur_dur_q   <= '0;
            open_q      <= 1'b0;
            open_val_q  <= '0;
            open_tone_q <= '0;
            vout_q      <= '0;
            tout_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            full_q      <= full_d;
            presc_q     <= presc_d;
            dcnt_q      <= dcnt_d;
            cur_dur_q   <= cur_dur_d;
            open_q      <= open_d;
            open_val_q  <= open_val_d;
            open_tone_q <= open_tone_d;
            vout_q      <= vout_d;
            tout_q      <= tout_d;
        end
    end

    assign value_out = vout_q;
    assign tone_out  = tout_q;
    assign playing   = (state_q == S_PLAY);
    assign recording = (state_q == S_REC);
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (64-entry and 4-entry buffers),
// an event-level model of what was recorded and what playback must emit.
module tb_note_sequencer;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rec0, play0, loop0, rec1, play1, loop1;
    logic [2:0] val0, val1;
    logic [1:0] tone0, tone1;
    logic [2:0] vo0, vo1;
    logic [1:0] to0, to1;
    logic       pl0, pl1, rc0, rc1, fu0, fu1;
    logic [6:0] cnt0;
    logic [2:0] cnt1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    typedef struct packed {
        logic       p;
        logic [2:0] v;
        logic [1:0] t;
        logic       tc;
    } exp_t;
    typedef struct {
        int v;
        int t;
        int d;
    } ent_t;

    exp_t q0[$];
    exp_t q1[$];
    ent_t ents0[$];
    ent_t ents1[$];
    int   seg_v[$];
    int   seg_t[$];
    int   seg_l[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    note_sequencer #(.VAL_W(3), .TONE_W(2), .ADDR_W(6), .DUR_W(8), .TICK_DIV(T)) dut (
        .clk(clk), .rst(rst), .rec_en(rec0), .play_en(play0), .loop(loop0),
        .value_in(val0), .tone_in(tone0), .value_out(vo0), .tone_out(to0),
        .playing(pl0), .recording(rc0), .full(fu0), .count(cnt0));

    note_sequencer #(.VAL_W(3), .TONE_W(2), .ADDR_W(2), .DUR_W(8), .TICK_DIV(T)) dut2 (
        .clk(clk), .rst(rst), .rec_en(rec1), .play_en(play1), .loop(loop1),
        .value_in(val1), .tone_in(tone1), .value_out(vo1), .tone_out(to1),
        .playing(pl1), .recording(rc1), .full(fu1), .count(cnt1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input int v, input int t);
        if (d == 0) begin val0 = 3'(v); tone0 = 2'(t); end
        else        begin val1 = 3'(v); tone1 = 2'(t); end
    endtask

    // hold a live note (or silence) for n clk cycles, logging it for the model
    task automatic hold(input int d, input int v, input int t, input int n);
        drive(d, v, t);
        seg_v.push_back(v);
        seg_t.push_back(t);
        seg_l.push_back(n);
        step(n);
    endtask

    // model: what the buffer must hold after a take, from the logged segments
    function automatic void build(input int d);
        ent_t e[$];
        int   depth;
        bit   started;
        depth   = (d == 0) ? 64 : 4;
        started = 1'b0;
        for (int i = 0; i < seg_v.size(); i++) begin
            int du;
            if (!started && seg_v[i] == 0) continue;
            started = 1'b1;
            du = seg_l[i] / T;
            if (du < 1)   du = 1;
            if (du > 255) du = 255;
            e.push_back('{seg_v[i], seg_t[i], du});
        end
        if (e.size() > 0 && e[e.size()-1].v == 0) void'(e.pop_back());
        while (e.size() > depth) void'(e.pop_back());
        if (d == 0) ents0 = e; else ents1 = e;
    endfunction

    task automatic rec_start(input int d);
        if (d == 0) rec0 = 1'b1; else rec1 = 1'b1;
        seg_v.delete();
        seg_t.delete();
        seg_l.delete();
        hold(d, 0, 0, 6);
    endtask

    task automatic rec_stop(input int d);
        if (d == 0) rec0 = 1'b0; else rec1 = 1'b0;
        drive(d, 0, 0);
        build(d);
        step(6);
    endtask

    // raise play and queue the per-cycle outputs playback must produce
    task automatic play_start(input int d, input bit lp, input int reps);
        exp_t idle;
        exp_t x;
        ent_t es[$];
        idle = '0;
        if (d == 0) begin es = ents0; loop0 = lp; play0 = 1'b1; end
        else        begin es = ents1; loop1 = lp; play1 = 1'b1; end
        repeat (3) begin
            if (d == 0) q0.push_back(idle); else q1.push_back(idle);
        end
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < es.size(); i++) begin
                x.p  = 1'b1;
                x.v  = 3'(es[i].v);
                x.t  = 2'(es[i].t);
                x.tc = (es[i].v != 0);
                repeat (es[i].d * T) begin
                    if (d == 0) q0.push_back(x); else q1.push_back(x);
                end
            end
        end
    endtask

    // dropping play leaves exactly three more playing cycles (sync + state)
    task automatic play_stop(input int d);
        if (d == 0) begin
            play0 = 1'b0;
            while (q0.size() > 3) void'(q0.pop_back());
        end else begin
            play1 = 1'b0;
            while (q1.size() > 3) void'(q1.pop_back());
        end
    endtask

    task automatic wait_drain(input int d);
        int left;
        for (int i = 0; i < 3000; i++) begin
            left = (d == 0) ? q0.size() : q1.size();
            if (left == 0) break;
            @(posedge clk);
        end
        #1;
        left = (d == 0) ? q0.size() : q1.size();
        chk("drain", 32'(left), 32'd0);
    endtask

    // per-cycle compare of both instances against the expected playback stream
    always @(negedge clk) begin
        if (chk_on) begin
            if (q0.size() > 0) e0 = q0.pop_front(); else e0 = '0;
            if (q1.size() > 0) e1 = q1.pop_front(); else e1 = '0;
            chk("stream0", 32'({pl0, vo0, (e0.tc ? to0 : 2'b00)}),
                32'({e0.p, e0.v, (e0.tc ? e0.t : 2'b00)}));
            chk("stream1", 32'({pl1, vo1, (e1.tc ? to1 : 2'b00)}),
                32'({e1.p, e1.v, (e1.tc ? e1.t : 2'b00)}));
        end
    end

    initial begin
        rst = 1'b1;
        rec0 = 1'b0; play0 = 1'b0; loop0 = 1'b0; val0 = '0; tone0 = '0;
        rec1 = 1'b0; play1 = 1'b0; loop1 = 1'b0; val1 = '0; tone1 = '0;
        step(3);
        chk("reset0", 32'({pl0, rc0, fu0, cnt0, vo0, to0}), 32'd0);
        chk("reset1", 32'({pl1, rc1, fu1, cnt1, vo1, to1}), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;
        step(3);

        // 1: record three events, replay once
        rec_start(0);
        hold(0, 3, 1, 40);
        hold(0, 0, 0, 20);
        hold(0, 5, 2, 24);
        rec_stop(0);
        chk("t1_nent", 32'(ents0.size()), 32'd3);
        chk("t1_dur0", 32'(ents0[0].d), 32'd10);
        chk("t1_dur1", 32'(ents0[1].d), 32'd5);
        chk("t1_dur2", 32'(ents0[2].d), 32'd6);
        chk("t1_count", 32'(cnt0), 32'd3);
        chk("t1_full", 32'(fu0), 32'd0);
        chk("t1_rec_off", 32'(rc0), 32'd0);
        play_start(0, 1'b0, 1);
        chk("t1_len", 32'(q0.size()), 32'd87);
        step(3);
        chk("t1_first", 32'({pl0, vo0, to0}), 32'({1'b1, 3'd3, 2'd1}));
        wait_drain(0);
        chk("t1_end", 32'({pl0, vo0, to0}), 32'd0);
        play0 = 1'b0;
        step(4);

        // 2: looped replay, wrap with no gap, stop mid-entry
        play_start(0, 1'b1, 3);
        step(86);
        chk("t2_pre_wrap", 32'(vo0), 32'd5);
        step(1);
        chk("t2_wrap", 32'({pl0, vo0}), 32'({1'b1, 3'd3}));
        step(30);
        play_stop(0);
        step(2);
        chk("t2_stop_lat2", 32'(pl0), 32'd1);
        step(1);
        chk("t2_stop_lat3", 32'({pl0, vo0, to0}), 32'd0);
        loop0 = 1'b0;
        step(4);

        // 6: reset in the middle of playback
        play_start(0, 1'b0, 1);
        step(30);
        q0.delete();
        #2 rst = 1'b1;
        #1;
        chk("t6_async", 32'({pl0, vo0, to0, cnt0}), 32'd0);
        step(3);
        rst = 1'b0;
        step(8);
        chk("t6_idle_hi", 32'(pl0), 32'd0);
        play0 = 1'b0;
        step(4);
        play0 = 1'b1;
        step(6);
        chk("t6_play_empty", 32'({pl0, vo0, cnt0}), 32'd0);
        play0 = 1'b0;
        step(4);

        // 4: long hold saturates the duration field
        rec_start(0);
        hold(0, 7, 3, 1200);
        rec_stop(0);
        chk("t4_nent", 32'(ents0.size()), 32'd1);
        chk("t4_dur", 32'(ents0[0].d), 32'd255);
        chk("t4_count", 32'(cnt0), 32'd1);
        play_start(0, 1'b0, 1);
        chk("t4_len", 32'(q0.size()), 32'd1023);
        wait_drain(0);
        chk("t4_end", 32'(pl0), 32'd0);
        play0 = 1'b0;
        step(4);

        // 5: rec and play together -> REC wins; play with empty buffer
        play0 = 1'b1;
        rec_start(0);
        chk("t5_rec", 32'({rc0, pl0, cnt0}), 32'({1'b1, 1'b0, 7'd0}));
        play0 = 1'b0;
        rec_stop(0);
        chk("t5_empty", 32'({rc0, cnt0}), 32'd0);
        step(2);
        play0 = 1'b1;
        step(6);
        chk("t5_play_empty", 32'({pl0, vo0}), 32'd0);
        play0 = 1'b0;
        step(4);

        // 3: small buffer fills after four entries
        rec_start(1);
        for (int i = 1; i <= 6; i++) begin
            hold(1, i, i % 4, 8);
            if (i == 4) chk("t3_before_full", 32'({fu1, cnt1}), 32'({1'b0, 3'd3}));
            if (i == 5) chk("t3_full", 32'({fu1, cnt1}), 32'({1'b1, 3'd4}));
        end
        rec_stop(1);
        chk("t3_nent", 32'(ents1.size()), 32'd4);
        chk("t3_count", 32'({fu1, cnt1}), 32'({1'b1, 3'd4}));
        play_start(1, 1'b0, 1);
        chk("t3_len", 32'(q1.size()), 32'd35);
        wait_drain(1);
        chk("t3_end", 32'({pl1, vo1}), 32'd0);
        play1 = 1'b0;
        step(4);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
